// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER pipeline stages.
//   pc_src_t     : next-PC select codes driven by the control unit
//   opcode_t     : RV32I major opcodes shared with the stage decoders
//   skid_state_t : state of the fetch-stage holding buffer
//   NOP_INSTR    : canonical bubble instruction (addi x0,x0,0)
package otter_pkg;

   typedef enum logic [2:0] {
      PC_PLUS4  = 3'd0,
      PC_JALR   = 3'd1,
      PC_BRANCH = 3'd2,
      PC_JAL    = 3'd3,
      PC_MTVEC  = 3'd4,
      PC_MEPC   = 3'd5
   } pc_src_t;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011,
      OP_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic {
      SKID_EMPTY = 1'b0,
      SKID_FULL  = 1'b1
   } skid_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/otter_fetch_skid.sv
// One-entry holding buffer for the fetch stage. When decode is stalled the
// instruction-memory response that was already in flight has nowhere to go;
// it is parked here and handed to decode on the first unstalled cycle.
// Ports:
//   clk, srst        : clock, synchronous active-high reset
//   capture          : park in_data/in_pc (only honoured while EMPTY)
//   release_req      : decode is consuming the entry this cycle
//   flush            : drop the entry (redirect / clear)
//   in_data, in_pc   : response word and its address
//   data, pc, valid  : parked entry, valid while FULL
module otter_fetch_skid
   import otter_pkg::*;
(
   input  logic        clk,
   input  logic        srst,
   input  logic        capture,
   input  logic        release_req,
   input  logic        flush,
   input  logic [31:0] in_data,
   input  logic [31:0] in_pc,
   output logic [31:0] data,
   output logic [31:0] pc,
   output logic        valid
);

   skid_state_t state_reg;
   logic [31:0] data_reg;
   logic [31:0] pc_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg <= SKID_EMPTY;
      end else begin
         case (state_reg)
            SKID_EMPTY: begin
               if (capture && !flush) begin
                  state_reg <= SKID_FULL;
                  data_reg  <= in_data;
                  pc_reg    <= in_pc;
               end
            end
            SKID_FULL: begin
               if (flush || release_req)
                  state_reg <= SKID_EMPTY;
            end
            default: state_reg <= SKID_EMPTY;
         endcase
      end
   end

   assign data  = data_reg;
   assign pc    = pc_reg;
   assign valid = (state_reg == SKID_FULL);

endmodule

// File: rtl/otter_fetch_stage.sv
// Instruction-fetch stage of the pipelined OTTER core. Holds the PC, selects
// the next PC, issues synchronous instruction-memory reads (data one cycle
// after the request) and drives the decode-stage instruction register.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   PC_SOURCE                : next-PC select (0 = PC+4, 1..5 = redirect, 6..7 = PC+4)
//   JALR_TGT .. MEPC         : redirect targets
//   STALL                    : hold fetch and decode
//   CLEAR                    : flush decode and the in-flight fetch
//   IMEM_ADDR, IMEM_RDEN     : fetch request
//   IMEM_DATA                : fetch response, one cycle after IMEM_RDEN
//   DEC_IR, DEC_PC           : decode-stage instruction and its address
//   DEC_NEXT_PC              : DEC_PC + 4 (link value)
//   DEC_VALID                : DEC_IR is a real instruction
module otter_fetch_stage #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = otter_pkg::NOP_INSTR
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [2:0]  PC_SOURCE,
   input  logic [31:0] JALR_TGT,
   input  logic [31:0] BRANCH_TGT,
   input  logic [31:0] JAL_TGT,
   input  logic [31:0] MTVEC,
   input  logic [31:0] MEPC,
   input  logic        STALL,
   input  logic        CLEAR,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_RDEN,
   input  logic [31:0] IMEM_DATA,
   output logic [31:0] DEC_IR,
   output logic [31:0] DEC_PC,
   output logic [31:0] DEC_NEXT_PC,
   output logic        DEC_VALID
);
   import otter_pkg::*;

   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] redirect_tgt;
   logic        redirect;
   logic        flush;

   logic        req_valid_reg;
   logic [31:0] req_pc_reg;

   logic [31:0] skid_data;
   logic [31:0] skid_pc;
   logic        skid_valid;

   logic [31:0] dec_ir_reg;
   logic [31:0] dec_pc_reg;
   logic        dec_valid_reg;

   // Unused codes 6..7 fall into the default arm and behave as PC+4.
   always_comb begin
      redirect     = 1'b1;
      redirect_tgt = pc_reg;
      case (pc_src_t'(PC_SOURCE))
         PC_JALR:   redirect_tgt = JALR_TGT;
         PC_BRANCH: redirect_tgt = BRANCH_TGT;
         PC_JAL:    redirect_tgt = JAL_TGT;
         PC_MTVEC:  redirect_tgt = MTVEC;
         PC_MEPC:   redirect_tgt = MEPC;
         default:   redirect     = 1'b0;
      endcase
   end

   assign flush = redirect || CLEAR;

   // A redirect beats STALL: the stalled instruction is flushed anyway.
   always_comb begin
      if (redirect)
         pc_next = redirect_tgt;
      else if (STALL)
         pc_next = pc_reg;
      else
         pc_next = pc_reg + 32'd4;
   end

   always_ff @(posedge CLK) begin
      if (RST)
         pc_reg <= RESET_VEC;
      else
         pc_reg <= pc_next;
   end

   // No request while stalled keeps at most one response outstanding, which
   // is what lets a single skid entry absorb it. No request on flush either:
   // the PC is about to change and the fetched word would be thrown away.
   assign IMEM_ADDR = pc_reg;
   assign IMEM_RDEN = !RST && !STALL && !flush;

   always_ff @(posedge CLK) begin
      if (RST || flush)
         req_valid_reg <= 1'b0;
      else
         req_valid_reg <= IMEM_RDEN;
      req_pc_reg <= pc_reg;
   end

   otter_fetch_skid u_skid (
      .clk         (CLK),
      .srst        (RST),
      .capture     (STALL && req_valid_reg && !flush),
      .release_req (!STALL),
      .flush       (flush),
      .in_data     (IMEM_DATA),
      .in_pc       (req_pc_reg),
      .data        (skid_data),
      .pc          (skid_pc),
      .valid       (skid_valid)
   );

   // Priority: reset > flush > stall > load. DEC_PC is left alone on flush so
   // the bubble still carries a sensible address.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dec_ir_reg    <= NOP_INSTR;
         dec_pc_reg    <= RESET_VEC;
         dec_valid_reg <= 1'b0;
      end else if (flush) begin
         dec_ir_reg    <= NOP_INSTR;
         dec_valid_reg <= 1'b0;
      end else if (!STALL) begin
         if (skid_valid) begin
            dec_ir_reg    <= skid_data;
            dec_pc_reg    <= skid_pc;
            dec_valid_reg <= 1'b1;
         end else begin
            dec_ir_reg    <= IMEM_DATA;
            dec_pc_reg    <= req_pc_reg;
            dec_valid_reg <= req_valid_reg;
         end
      end
   end

   assign DEC_IR      = dec_ir_reg;
   assign DEC_PC      = dec_pc_reg;
   assign DEC_NEXT_PC = dec_pc_reg + 32'd4;
   assign DEC_VALID   = dec_valid_reg;

endmodule
